alu_issue_ctrl: RTL



---
 rtl/alu_isa_pkg.sv | 85 ++++++++
 rtl/alu_issue_decode.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_isa_pkg.sv
// Shared CR16 ALU encoding: ALU opcodes, instruction op nibbles, flag positions,
// and the issue-controller state encoding.
package alu_isa_pkg;

    // Register-form ALU opcodes: {4'h0, ext}
    localparam logic [7:0] ALU_WAIT  = 8'h00;
    localparam logic [7:0] ALU_AND   = 8'h01;
    localparam logic [7:0] ALU_OR    = 8'h02;
    localparam logic [7:0] ALU_XOR   = 8'h03;
    localparam logic [7:0] ALU_NOT   = 8'h04;
    localparam logic [7:0] ALU_ADD   = 8'h05;
    localparam logic [7:0] ALU_ADDU  = 8'h06;
    localparam logic [7:0] ALU_ADDC  = 8'h07;
    localparam logic [7:0] ALU_LSH   = 8'h08;
    localparam logic [7:0] ALU_SUB   = 8'h09;
    localparam logic [7:0] ALU_SUBC  = 8'h0A;
    localparam logic [7:0] ALU_CMP   = 8'h0B;
    localparam logic [7:0] ALU_RSH   = 8'h0C;
    localparam logic [7:0] ALU_MOV   = 8'h0D;
    localparam logic [7:0] ALU_MUL   = 8'h0E;
    localparam logic [7:0] ALU_ARSH  = 8'h0F;

    // Immediate-form ALU opcodes: {op, 4'h0}
    localparam logic [7:0] ALU_ADDI  = 8'h50;
    localparam logic [7:0] ALU_ADDUI = 8'h60;
    localparam logic [7:0] ALU_ADDCI = 8'h70;
    localparam logic [7:0] ALU_LSHI  = 8'h80;
    localparam logic [7:0] ALU_SUBI  = 8'h90;
    localparam logic [7:0] ALU_SUBCI = 8'hA0;
    localparam logic [7:0] ALU_CMPI  = 8'hB0;
    localparam logic [7:0] ALU_RSHI  = 8'hC0;
    localparam logic [7:0] ALU_MOVI  = 8'hD0;
    localparam logic [7:0] ALU_MULI  = 8'hE0;
    localparam logic [7:0] ALU_ARSHI = 8'hF0;

    localparam logic [3:0] NIB_REG   = 4'h0;
    localparam logic [3:0] NIB_ADDI  = 4'h5;
    localparam logic [3:0] NIB_ADDUI = 4'h6;
    localparam logic [3:0] NIB_ADDCI = 4'h7;
    localparam logic [3:0] NIB_LSHI  = 4'h8;
    localparam logic [3:0] NIB_SUBI  = 4'h9;
    localparam logic [3:0] NIB_SUBCI = 4'hA;
    localparam logic [3:0] NIB_CMPI  = 4'hB;
    localparam logic [3:0] NIB_RSHI  = 4'hC;
    localparam logic [3:0] NIB_MOVI  = 4'hD;
    localparam logic [3:0] NIB_MULI  = 4'hE;
    localparam logic [3:0] NIB_ARSHI = 4'hF;

    localparam int FLAG_L = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [4:0] FMASK_NONE  = 5'b00000;
    localparam logic [4:0] FMASK_ARITH = 5'b11111;
    localparam logic [4:0] FMASK_MUL   = 5'((1 << FLAG_C) | (1 << FLAG_Z) | (1 << FLAG_N));
    localparam logic [4:0] FMASK_LOGIC = 5'((1 << FLAG_Z) | (1 << FLAG_N));
    localparam logic [4:0] FMASK_CMP   = 5'((1 << FLAG_L) | (1 << FLAG_Z) | (1 << FLAG_N));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } issue_state_e;

    // PSR bits the ALU is trusted to produce for a given opcode; the rest are don't-care.
    function automatic logic [4:0] flag_mask_of(input logic [7:0] op);
        logic [4:0] m;
        case (op)
            ALU_ADD, ALU_ADDU, ALU_ADDC, ALU_SUB, ALU_SUBC,
            ALU_ADDI, ALU_ADDUI, ALU_ADDCI, ALU_SUBI, ALU_SUBCI: m = FMASK_ARITH;
            ALU_MUL, ALU_MULI:                                  m = FMASK_MUL;
            ALU_CMP, ALU_CMPI:                                  m = FMASK_CMP;
            ALU_WAIT:                                           m = FMASK_NONE;
            default:                                            m = FMASK_LOGIC;
        endcase
        return m;
    endfunction

    function automatic logic is_sext_imm(input logic [3:0] nib);
        return nib inside {NIB_ADDI, NIB_ADDCI, NIB_SUBI, NIB_SUBCI, NIB_CMPI, NIB_MULI};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational CR16 word decode into ALU opcode, immediate operand and
// writeback/flag-commit controls.
module alu_issue_decode
    import alu_isa_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op_i,
    input  logic [7:0]        imm_i,
    output logic [7:0]        alu_op_o,
    output logic [DATA_W-1:0] imm_ext_o,
    output logic              use_imm_o,
    output logic              wb_en_o,
    output logic [4:0]        flag_mask_o,
    output logic              illegal_o
);

    always_comb begin
        alu_op_o    = ALU_WAIT;
        imm_ext_o   = '0;
        use_imm_o   = 1'b0;
        illegal_o   = 1'b0;

        case (op_i)
            NIB_REG: alu_op_o = {4'h0, imm_i[7:4]};
            4'h1, 4'h2, 4'h3, 4'h4: illegal_o = 1'b1;
            default: begin
                alu_op_o  = {op_i, 4'h0};
                use_imm_o = 1'b1;
                if (is_sext_imm(op_i))
                    imm_ext_o = {{(DATA_W-8){imm_i[7]}}, imm_i};
                else
                    imm_ext_o = {{(DATA_W-8){1'b0}}, imm_i};
            end
        endcase

        flag_mask_o = illegal_o ? FMASK_NONE : flag_mask_of(alu_op_o);
        wb_en_o     = !illegal_o && !(alu_op_o inside {ALU_WAIT, ALU_CMP, ALU_CMPI});
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial issue/writeback controller around the combinational CR16 ALU:
// accept -> EXEC (operands out, result captured) -> WB (regfile/PSR commit).
//
// state   | meaning
// IDLE    | instr_ready=1, waiting for a word
// EXEC    | ALU driven from latched word, result/flags captured at edge
// WB      | done pulse, regfile and masked PSR written at edge
module alu_issue_ctrl
    import alu_isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 1 << ADDR_W;

    issue_state_e      state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        flags_q;
    logic [4:0]        psr_q, psr_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic              accept;

    logic [7:0]        dec_alu_op;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_use_imm;
    logic              dec_wb_en;
    logic [4:0]        dec_flag_mask;
    logic              dec_illegal;

    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] rs_idx;

    assign rd_idx = instr_q[8 +: ADDR_W];
    assign rs_idx = instr_q[0 +: ADDR_W];

    alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
        .op_i        (instr_q[15:12]),
        .imm_i       (instr_q[7:0]),
        .alu_op_o    (dec_alu_op),
        .imm_ext_o   (dec_imm),
        .use_imm_o   (dec_use_imm),
        .wb_en_o     (dec_wb_en),
        .flag_mask_o (dec_flag_mask),
        .illegal_o   (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        psr_d       = psr_q;
        accept      = 1'b0;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        alu_op      = ALU_WAIT;
        alu_a       = '0;
        alu_b       = '0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = dec_alu_op;
                alu_a   = rf_q[rd_idx];
                alu_b   = dec_use_imm ? dec_imm : rf_q[rs_idx];
                state_d = ST_WB;
            end
            ST_WB: begin
                // A reset landing in WB aborts the retire, so the pulse is suppressed too.
                done    = !reset;
                illegal = !reset && dec_illegal;
                psr_d   = (psr_q & ~dec_flag_mask) | (flags_q & dec_flag_mask);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
            psr_q   <= '0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            if (accept)
                instr_q <= instr;
            if (state_q == ST_EXEC) begin
                res_q   <= alu_result;
                flags_q <= alu_flags;
            end
            if (state_q == ST_WB && dec_wb_en)
                rf_q[rd_idx] <= res_q;
        end
    end

    assign psr      = psr_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule
